spio_status_led_decoder: RTL and testbench
==========================================

Name: spio_status_led_decoder

Overview:
- Receive end of the status-LED PWM scheme, used for board self-test and for reading LED state back to management logic.
- Samples one PWM-driven LED line (from the LED generator, or an LED sense input) and recovers the PWM duty of every PWM window.
- Classifies each animation period's duty sequence as OFF, ON, PULSE, NOTCH (error), BLINK or THROB.
- Needs no phase alignment with the generator.

Parameters:
- PWM_BITS, 7, log2 of PWM window length in cycles; must match the generator.
- ANIMATION_PERIOD_BITS, 27, log2 of the classification period in cycles; must be > PWM_BITS+2.
- LOW_THRESH, 1, a window with duty <= this value is LOW.
- HIGH_THRESH, 126, a window with duty >= this value is HIGH; anything between is MID.

Ports:
- CLK_IN  in  1  clock
- RESET_IN  in  1  asynchronous, active-high reset
- LED_IN  in  1  LED drive/sense line; may be asynchronous to CLK_IN
- DUTY_OUT  out  PWM_BITS+1  high-cycle count of the last completed window (0..2^PWM_BITS)
- DUTY_VLD_OUT  out  1  one-cycle pulse when DUTY_OUT updates
- STATE_OUT  out  3  0 UNKNOWN, 1 OFF, 2 ON, 3 PULSE, 4 NOTCH, 5 BLINK, 6 THROB
- STATE_VLD_OUT  out  1  one-cycle pulse when STATE_OUT updates

Behaviour:
- Reset (async, all state):
  - DUTY_OUT=0, DUTY_VLD_OUT=0, STATE_OUT=0 (UNKNOWN), STATE_VLD_OUT=0.
  - All counters and accumulators cleared; last-class register = NONE.
  - Reset mid-period discards the partial period.
- Input sync: LED_IN passes through a 2-flop synchroniser (resets to 0). Call the synchronised value s.
- Window counter:
  - Free-running PWM_BITS counter w, 0 after reset.
  - Accumulator hi (PWM_BITS+1 bits) adds s each cycle.
  - In the cycle w = 2^PWM_BITS-1: DUTY_OUT <= hi+s, DUTY_VLD_OUT <= 1, hi <= 0.
  - Constant 1 gives 2^PWM_BITS; constant 0 gives 0. For any periodic 2^PWM_BITS pattern, the result is exact regardless of phase.
- Window classification happens in the cycle DUTY_VLD_OUT=1, using DUTY_OUT:
  - Class is LOW, MID or HIGH per the thresholds.
  - The matching counter low_cnt, mid_cnt or high_cnt increments; each is ANIMATION_PERIOD_BITS-PWM_BITS+1 bits wide.
  - Transitions: if class is LOW or HIGH and differs from the last non-MID class (not NONE), trans increments, saturating at 3. The last non-MID class then updates.
  - MID windows never change the last class, so LOW->MID->HIGH counts as one transition.
- Period:
  - N = 2^(ANIMATION_PERIOD_BITS-PWM_BITS) windows, counted by window index wi, which wraps.
  - On the accumulation cycle of window wi = N-1, the next cycle has STATE_VLD_OUT=1 with STATE_OUT set by the first matching rule:
    1. mid_cnt >= N/4 -> THROB
    2. trans=0 and high_cnt=0 -> OFF
    3. trans=0 and low_cnt=0 -> ON
    4. trans=3 -> BLINK
    5. low_cnt >= high_cnt -> PULSE
    6. otherwise -> NOTCH
  - In the same cycle, low_cnt, mid_cnt, high_cnt and trans clear. The last non-MID class persists across periods, so a pulse split across a period boundary yields one transition in each period.
- Timing from reset release:
  - First DUTY_VLD_OUT at cycle 2^PWM_BITS.
  - First STATE_VLD_OUT at cycle 2^ANIMATION_PERIOD_BITS+1, then every 2^ANIMATION_PERIOD_BITS cycles.
  - STATE_OUT holds between pulses.
- Simultaneous events: window end and period end coincide by construction. The final window is included in that period's evaluation and is not counted in the next.

Test Plan (PWM_BITS=4, ANIMATION_PERIOD_BITS=14, LOW_THRESH=1, HIGH_THRESH=14; N=1024, period 16384):
- LED_IN=0 constant.
  -> DUTY_OUT=0 on every DUTY_VLD_OUT (first at cycle 16).
  -> STATE_OUT=1 with STATE_VLD_OUT at cycle 16385, then every 16384.
- LED_IN=1 constant -> DUTY_OUT=16 -> ON (2). Then LED_IN 15 high/1 low per 16 cycles at an arbitrary phase -> DUTY_OUT=15 -> still ON.
- LED_IN=0 except one 800-cycle high burst inside a period -> PULSE (3). Inverse (constant 1 with one 800-cycle low gap) -> NOTCH (4).
- LED_IN toggling every 1024 cycles -> BLINK (5) in every period; no DUTY_OUT value other than 0 or 16 except boundary-phase windows.
- Duty ramped 0..15 then 15..0, stepping each 64 windows -> mid_cnt >= 256 -> THROB (6).
- RESET_IN pulsed at cycle 9000 of a BLINK stream.
  -> Outputs return to 0 / UNKNOWN asynchronously.
  -> Next STATE_VLD_OUT exactly 16385 cycles after release.
  -> No stale counts carried over.

Source files
------------

// File: rtl/spio_status_led_decoder.sv
// Status-LED receiver: recovers per-window PWM duty from one LED line and classifies
// each animation period as OFF / ON / PULSE / NOTCH / BLINK / THROB.
module spio_status_led_decoder #(
    parameter int PWM_BITS              = 7,
    parameter int ANIMATION_PERIOD_BITS = 27,
    parameter int LOW_THRESH            = 1,
    parameter int HIGH_THRESH           = 126
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                LED_IN,
    output logic [PWM_BITS:0]   DUTY_OUT,
    output logic                DUTY_VLD_OUT,
    output logic [2:0]          STATE_OUT,
    output logic                STATE_VLD_OUT
);

    localparam int DW  = PWM_BITS + 1;
    localparam int WIB = ANIMATION_PERIOD_BITS - PWM_BITS;
    localparam int CW  = WIB + 1;

    localparam logic [DW-1:0] LO_T    = DW'(LOW_THRESH);
    localparam logic [DW-1:0] HI_T    = DW'(HIGH_THRESH);
    localparam logic [CW-1:0] QUARTER = CW'(1 << (WIB - 2));

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LOW  = 2'd1,
        CLS_MID  = 2'd2,
        CLS_HIGH = 2'd3
    } cls_t;

    typedef enum logic [2:0] {
        ST_UNKNOWN = 3'd0,
        ST_OFF     = 3'd1,
        ST_ON      = 3'd2,
        ST_PULSE   = 3'd3,
        ST_NOTCH   = 3'd4,
        ST_BLINK   = 3'd5,
        ST_THROB   = 3'd6
    } led_state_t;

    logic                led_meta;
    logic                led_s;
    logic [PWM_BITS-1:0] w;
    logic [DW-1:0]       hi;
    logic [WIB-1:0]      wi;
    logic [CW-1:0]       low_cnt, mid_cnt, high_cnt;
    logic [1:0]          trans;
    cls_t                last_cls;

    cls_t                win_cls;
    logic [CW-1:0]       low_nxt, mid_nxt, high_nxt;
    logic [1:0]          trans_nxt;
    led_state_t          period_state;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            led_meta <= 1'b0;
            led_s    <= 1'b0;
        end else begin
            led_meta <= LED_IN;
            led_s    <= led_meta;
        end
    end

    // The window's final sample is folded straight into DUTY_OUT so no cycle is lost.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            w            <= '0;
            hi           <= '0;
            DUTY_OUT     <= '0;
            DUTY_VLD_OUT <= 1'b0;
        end else begin
            w <= w + 1'b1;
            if (&w) begin
                DUTY_OUT     <= hi + DW'(led_s);
                DUTY_VLD_OUT <= 1'b1;
                hi           <= '0;
            end else begin
                hi           <= hi + DW'(led_s);
                DUTY_VLD_OUT <= 1'b0;
            end
        end
    end

    // Next-count values include the current window, so the final window of a
    // period takes part in that period's verdict.
    always_comb begin
        win_cls = CLS_MID;
        if (DUTY_OUT <= LO_T) begin
            win_cls = CLS_LOW;
        end else if (DUTY_OUT >= HI_T) begin
            win_cls = CLS_HIGH;
        end

        low_nxt  = low_cnt  + CW'(win_cls == CLS_LOW);
        mid_nxt  = mid_cnt  + CW'(win_cls == CLS_MID);
        high_nxt = high_cnt + CW'(win_cls == CLS_HIGH);

        trans_nxt = trans;
        if (win_cls != CLS_MID && last_cls != CLS_NONE &&
            win_cls != last_cls && trans != 2'd3) begin
            trans_nxt = trans + 2'd1;
        end

        period_state = ST_NOTCH;
        if (mid_nxt >= QUARTER) begin
            period_state = ST_THROB;
        end else if (trans_nxt == 2'd0 && high_nxt == '0) begin
            period_state = ST_OFF;
        end else if (trans_nxt == 2'd0 && low_nxt == '0) begin
            period_state = ST_ON;
        end else if (trans_nxt == 2'd3) begin
            period_state = ST_BLINK;
        end else if (low_nxt >= high_nxt) begin
            period_state = ST_PULSE;
        end
    end

    // last_cls survives the period boundary so split pulses are seen in both periods.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            wi            <= '0;
            low_cnt       <= '0;
            mid_cnt       <= '0;
            high_cnt      <= '0;
            trans         <= 2'd0;
            last_cls      <= CLS_NONE;
            STATE_OUT     <= ST_UNKNOWN;
            STATE_VLD_OUT <= 1'b0;
        end else begin
            STATE_VLD_OUT <= 1'b0;
            if (DUTY_VLD_OUT) begin
                wi <= wi + 1'b1;
                if (win_cls != CLS_MID) begin
                    last_cls <= win_cls;
                end
                if (&wi) begin
                    STATE_OUT     <= period_state;
                    STATE_VLD_OUT <= 1'b1;
                    low_cnt       <= '0;
                    mid_cnt       <= '0;
                    high_cnt      <= '0;
                    trans         <= 2'd0;
                end else begin
                    low_cnt  <= low_nxt;
                    mid_cnt  <= mid_nxt;
                    high_cnt <= high_nxt;
                    trans    <= trans_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_spio_status_led_decoder.sv
// Directed bench for spio_status_led_decoder with a shortened animation period.
module tb_spio_status_led_decoder;

    localparam int PWM = 4;
    localparam int APB = 11;
    localparam int WIN = 1 << PWM;
    localparam int P   = 1 << APB;
    localparam int N   = P / WIN;

    localparam int S_UNKNOWN = 0, S_OFF = 1, S_ON = 2, S_PULSE = 3;
    localparam int S_NOTCH = 4, S_BLINK = 5, S_THROB = 6;

    logic           clk;
    logic           rst;
    logic           led;
    logic [PWM:0]   duty;
    logic           duty_vld;
    logic [2:0]     state;
    logic           state_vld;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pat_mode  = 0;
    int pat_start = 0;
    int cyc_n, first_dv;

    spio_status_led_decoder #(
        .PWM_BITS(PWM), .ANIMATION_PERIOD_BITS(APB),
        .LOW_THRESH(1), .HIGH_THRESH(14)
    ) dut (
        .CLK_IN(clk), .RESET_IN(rst), .LED_IN(led),
        .DUTY_OUT(duty), .DUTY_VLD_OUT(duty_vld),
        .STATE_OUT(state), .STATE_VLD_OUT(state_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern generator: LED level as a function of cycles since pat_start.
    always @(posedge clk) begin
        int rel, lvl;
        #1;
        rel = cyc - pat_start;
        case (pat_mode)
            1: led = 1'b1;
            2: led = ((rel + 5) % 16) != 0;
            3: led = (rel >= 400 && rel < 1200);
            4: led = !(rel >= 400 && rel < 1200);
            5: led = (((rel + 122) >> 7) & 1) == 0;
            6: begin
                lvl = (rel >> 7) % 32;
                if (lvl > 15) lvl = 31 - lvl;
                led = (rel % 16) < lvl;
            end
            default: led = 1'b0;
        endcase
        cyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_duty"},      int'(duty),      0);
        check({tag, "_duty_vld"},  int'(duty_vld),  0);
        check({tag, "_state"},     int'(state),     S_UNKNOWN);
        check({tag, "_state_vld"}, int'(state_vld), 0);
    endtask

    // Waits for the next STATE_VLD pulse, checking the period's windows on the way.
    task automatic wait_state(input string tag, input int exp_state, input int exp_duty,
                              input int exp_odd, output int cycles, output int first);
        int nwin = 0;
        int odd  = 0;
        bit seen = 0;
        cycles = 0;
        first  = -1;
        while (!seen && cycles < 2 * P + 64) begin
            @(negedge clk);
            cycles++;
            if (duty_vld) begin
                nwin++;
                if (first < 0) first = cycles;
                if (duty != 0 && duty != WIN) odd++;
                if (exp_duty >= 0 && nwin > 2) check({tag, "_duty"}, int'(duty), exp_duty);
            end
            if (state_vld) seen = 1;
        end
        check({tag, "_seen"}, int'(seen), 1);
        check({tag, "_state"}, int'(state), exp_state);
        check({tag, "_windows"}, nwin, N);
        if (exp_odd >= 0) check({tag, "_odd_windows"}, odd, exp_odd);
        @(negedge clk);
        check({tag, "_vld_pulse"}, int'(state_vld), 0);
    endtask

    initial begin
        rst = 1'b1;
        led = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst = 1'b0;
        wait_state("off", S_OFF, 0, -1, cyc_n, first_dv);
        check("first_duty_cycle", first_dv, WIN);
        check("first_state_cycle", cyc_n, P + 1);

        pat_mode = 3; pat_start = cyc;
        wait_state("pulse", S_PULSE, -1, -1, cyc_n, first_dv);
        check("period_len", cyc_n, P - 1);

        pat_mode = 1; pat_start = cyc;
        wait_state("low_to_high", S_NOTCH, WIN, -1, cyc_n, first_dv);

        wait_state("on", S_ON, WIN, 0, cyc_n, first_dv);

        pat_mode = 2; pat_start = cyc;
        wait_state("on15", S_ON, WIN - 1, -1, cyc_n, first_dv);

        pat_mode = 4; pat_start = cyc;
        wait_state("notch", S_NOTCH, -1, -1, cyc_n, first_dv);

        pat_mode = 5; pat_start = cyc;
        wait_state("blink", S_BLINK, -1, 16, cyc_n, first_dv);

        repeat (1100) @(negedge clk);
        check("hold_state", int'(state), S_BLINK);
        check("hold_vld", int'(state_vld), 0);

        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_state("blink_after_reset", S_BLINK, -1, -1, cyc_n, first_dv);
        check("reset_first_duty_cycle", first_dv, WIN);
        check("reset_state_cycle", cyc_n, P + 1);

        pat_mode = 6; pat_start = cyc;
        wait_state("throb_up", S_THROB, -1, -1, cyc_n, first_dv);
        wait_state("throb_down", S_THROB, -1, -1, cyc_n, first_dv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
